// File: rtl/mem_cmd_sequencer_if.sv
// mem_cmd_sequencer_if
//  Groups the Avalon-MM slave port and the mem_top command port of
//  mem_cmd_sequencer.
//  Signals:
//    chipselect, write, read, address[2:0], writedata[31:0] : host -> sequencer
//    readdata[31:0]                                         : sequencer -> host
//    mem_control[31:0], mem_data[31:0], mem_start           : sequencer -> mem_top
//    mem_ready[31:0], mem_answer[31:0]                      : mem_top -> sequencer
//  Modports:
//    slave  : the sequencer side
//    master : the host + mem_top side (driver/testbench)
interface mem_cmd_sequencer_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] mem_control;
  logic [31:0] mem_data;
  logic        mem_start;
  logic [31:0] mem_ready;
  logic [31:0] mem_answer;

  modport slave (
    input  chipselect, write, read, address, writedata, mem_ready, mem_answer,
    output readdata, mem_control, mem_data, mem_start
  );

  modport master (
    output chipselect, write, read, address, writedata, mem_ready, mem_answer,
    input  readdata, mem_control, mem_data, mem_start
  );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer
//  Avalon-MM register front end and command sequencer for mem_top.
//  The host stages a control word (addr 0), then pushes {control, data}
//  into a command FIFO (addr 1). An FSM pops each command, drives it to
//  mem_top with a one-cycle mem_start, waits for mem_ready[0] and captures
//  mem_answer into the result register. STATUS (addr 2), RESULT (addr 3,
//  clears res_valid) and CLEAR (addr 4) complete the register map.
//  Ports:
//    clk   : system clock
//    reset : asynchronous, active-high
//    bus   : mem_cmd_sequencer_if.slave (Avalon slave + mem_top port)
//  Parameters:
//    DEPTH          : command FIFO entries, power of 2, >= 2
//    TIMEOUT_CYCLES : WAIT cycles before abort (timeout build only)
//  Build option:
//    MEMSEQ_TIMEOUT_EN : when defined, WAIT aborts after TIMEOUT_CYCLES with
//                        result 32'hFFFF_FFFF and sets the sticky timeout flag.
module mem_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  mem_cmd_sequencer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mem_cmd_sequencer: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_cmd_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t state, state_nx;

  // host decode
  logic host_wr, host_rd;
  logic stage_wr, push_req, clear_wr, result_rd;
  assign host_wr   = bus.chipselect & bus.write;
  assign host_rd   = bus.chipselect & bus.read;
  assign stage_wr  = host_wr && (bus.address == 3'd0);
  assign push_req  = host_wr && (bus.address == 3'd1);
  assign clear_wr  = host_wr && (bus.address == 3'd4);
  assign result_rd = host_rd && (bus.address == 3'd3);

  logic [31:0] ctrl_stage;
  logic [31:0] mem_control_q, mem_data_q;
  logic [31:0] ans_hold, result;
  logic        res_valid, overflow, timeout_flag;

  // FIFO
  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, push_ok, ovf_set;
  cmd_t          head;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = fifo_mem[rd_ptr];
  // a pop in the same cycle frees the slot being written when full
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  logic start, ans_load, capture;

`ifdef MEMSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
`endif

  // FSM next state / control
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    start    = 1'b0;
    ans_load = 1'b0;
    capture  = 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        start    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (bus.mem_ready[0]) begin
          ans_load = 1'b1;
          state_nx = CAPTURE;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          to_hit   = 1'b1;
          state_nx = CAPTURE;
        end
`endif
      end
      CAPTURE: begin
        // a RESULT read this cycle frees the register for the new answer
        if (!res_valid || result_rd) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FIFO storage is not reset; count/pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= '{ctrl: ctrl_stage, data: bus.writedata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // datapath / flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_stage    <= '0;
      mem_control_q <= '0;
      mem_data_q    <= '0;
      ans_hold      <= '0;
      result        <= '0;
      res_valid     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (stage_wr) ctrl_stage <= bus.writedata;
      if (pop) begin
        mem_control_q <= head.ctrl;
        mem_data_q    <= head.data;
      end
      // hold the answer so mem_top may drop ready while CAPTURE stalls
      if (ans_load) ans_hold <= bus.mem_answer;
`ifdef MEMSEQ_TIMEOUT_EN
      if (to_hit)   ans_hold <= 32'hFFFF_FFFF;
`endif
      if (capture) begin
        result    <= ans_hold;
        res_valid <= 1'b1;
      end else if (result_rd) begin
        res_valid <= 1'b0;
      end
      if (ovf_set)                          overflow <= 1'b1;
      else if (clear_wr && bus.writedata[2]) overflow <= 1'b0;
    end
  end

`ifdef MEMSEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == WAIT) to_cnt <= to_cnt + 1'b1;
      else               to_cnt <= '0;
      if (to_hit)                            timeout_flag <= 1'b1;
      else if (clear_wr && bus.writedata[3]) timeout_flag <= 1'b0;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

  // register read
  logic [31:0] status;
  always_comb begin
    status      = '0;
    status[0]   = res_valid;
    status[1]   = (state != IDLE);
    status[2]   = overflow;
    status[3]   = timeout_flag;
    status[7:4] = 4'(count);
    status[8]   = full;
  end

  logic [31:0] readdata_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
    end else if (host_rd) begin
      case (bus.address)
        3'd2:    readdata_q <= status;
        3'd3:    readdata_q <= result;
        default: readdata_q <= '0;
      endcase
    end
  end

  logic unused_ready;
  assign unused_ready = ^bus.mem_ready[31:1];

  assign bus.readdata    = readdata_q;
  assign bus.mem_control = mem_control_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_start   = start;

endmodule
